// File: rtl/snake_motion.sv
// Snake head motion: advances the head one grid cell every TICK_DIV enabled cycles.
// Build option: define SNAKE_WRAP_AROUND_EN to wrap at the grid edges instead of stopping on a wall hit.
`ifndef TOP_DIR
`define TOP_DIR   2'b00
`endif
`ifndef DOWN_DIR
`define DOWN_DIR  2'b01
`endif
`ifndef LEFT_DIR
`define LEFT_DIR  2'b10
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'b11
`endif

module snake_motion #(
  parameter int         GRID_W    = 40,
  parameter int         GRID_H    = 30,
  parameter int         X_W       = 6,
  parameter int         Y_W       = 5,
  parameter int         TICK_DIV  = 5000000,
  parameter int         START_X   = 20,
  parameter int         START_Y   = 15,
  parameter logic [1:0] START_DIR = `TOP_DIR
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic [1:0]     iDirection,
  input  logic           iEnable,
  output logic [X_W-1:0] oHeadX,
  output logic [Y_W-1:0] oHeadY,
  output logic [1:0]     oCurDir,
  output logic           oStep,
  output logic           oHitWall,
  output logic [1:0]     oState
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   x_q, x_d, nx;
  logic [Y_W-1:0]   y_q, y_d, ny;
  logic [1:0]       dir_q, dir_d, cand;
  logic             step_q, step_d;
  logic             hit_q, hit_d;
  logic             wall;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= X_W'(START_X);
      y_q     <= Y_W'(START_Y);
      dir_q   <= START_DIR;
      step_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      hit_q   <= hit_d;
    end
  end

  // Opposite codes differ only in the LSB, so a reversal request keeps the current heading.
  assign cand = (iDirection == (dir_q ^ 2'b01)) ? dir_q : iDirection;

  // Next cell in the candidate direction; wall flags an attempt to leave the grid and
  // the coordinate falls back to the wrapped value.
  always_comb begin
    nx   = x_q;
    ny   = y_q;
    wall = 1'b0;
    unique case (cand)
      `TOP_DIR: begin
        if (y_q == '0) begin wall = 1'b1; ny = Y_W'(GRID_H - 1); end
        else ny = y_q - 1'b1;
      end
      `DOWN_DIR: begin
        if (y_q == Y_W'(GRID_H - 1)) begin wall = 1'b1; ny = '0; end
        else ny = y_q + 1'b1;
      end
      `LEFT_DIR: begin
        if (x_q == '0) begin wall = 1'b1; nx = X_W'(GRID_W - 1); end
        else nx = x_q - 1'b1;
      end
      default: begin
        if (x_q == X_W'(GRID_W - 1)) begin wall = 1'b1; nx = '0; end
        else nx = x_q + 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    hit_d   = hit_q;
    unique case (state_q)
      ST_IDLE: begin
        // The enabling edge counts as the first enabled cycle of the period.
        if (iEnable) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (iEnable) begin
          if (cnt_q == CNT_TC) begin
            cnt_d  = '0;
            step_d = 1'b1;
            dir_d  = cand;
`ifdef SNAKE_WRAP_AROUND_EN
            x_d = nx;
            y_d = ny;
`else
            if (wall) begin
              hit_d   = 1'b1;
              state_d = ST_DEAD;
            end else begin
              x_d = nx;
              y_d = ny;
            end
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign oHeadX  = x_q;
  assign oHeadY  = y_q;
  assign oCurDir = dir_q;
  assign oStep   = step_q;
  assign oState  = state_q;
`ifdef SNAKE_WRAP_AROUND_EN
  assign oHitWall = 1'b0;
`else
  assign oHitWall = hit_q;
`endif

endmodule

// File: tb/tb_snake_motion.sv
// Directed bench for snake_motion with TICK_DIV=4 on a 40x30 grid starting at (20,15) heading up.
`ifndef TOP_DIR
`define TOP_DIR   2'b00
`endif
`ifndef DOWN_DIR
`define DOWN_DIR  2'b01
`endif
`ifndef LEFT_DIR
`define LEFT_DIR  2'b10
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'b11
`endif

module tb_snake_motion;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic [1:0] iDirection = `TOP_DIR;
  logic       iEnable = 1'b0;
  logic [5:0] oHeadX;
  logic [4:0] oHeadY;
  logic [1:0] oCurDir;
  logic       oStep;
  logic       oHitWall;
  logic [1:0] oState;

  // {x, y, dir, step, hit}
  logic [14:0] status;
  logic [14:0] exp_st;
  int passed = 0;
  int total  = 0;
  int pulses;

  snake_motion #(
    .GRID_W(40), .GRID_H(30), .X_W(6), .Y_W(5), .TICK_DIV(4),
    .START_X(20), .START_Y(15), .START_DIR(`TOP_DIR)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iDirection(iDirection), .iEnable(iEnable),
    .oHeadX(oHeadX), .oHeadY(oHeadY), .oCurDir(oCurDir), .oStep(oStep),
    .oHitWall(oHitWall), .oState(oState)
  );

  always #5 iClk = ~iClk;

  assign status = {oHeadX, oHeadY, oCurDir, oStep, oHitWall};

  // Advance one edge and sample 1 ns later, away from the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic test_reset;
    iRst = 1'b1; iEnable = 1'b0; iDirection = `TOP_DIR;
    tick(2);
    iRst = 1'b0;
    exp_st = {6'd20, 5'd15, `TOP_DIR, 1'b0, 1'b0};
    total++; if (status !== exp_st) $display("FAIL reset_status got=%h exp=%h", status, exp_st); else passed++;
    total++; if (oState !== 2'd0) $display("FAIL reset_state got=%0d exp=0", oState); else passed++;
    tick(3);
    total++; if (status !== exp_st) $display("FAIL idle_hold got=%h exp=%h", status, exp_st); else passed++;
  endtask

  task automatic test_first_steps;
    iEnable = 1'b1; iDirection = `TOP_DIR;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin tick(1); pulses += int'(oStep); end
    total++; if (pulses !== 0) $display("FAIL early_step got=%0d exp=0", pulses); else passed++;
    tick(1);
    exp_st = {6'd20, 5'd14, `TOP_DIR, 1'b1, 1'b0};
    total++; if (status !== exp_st) $display("FAIL first_step got=%h exp=%h", status, exp_st); else passed++;
    tick(1);
    total++; if (oStep !== 1'b0) $display("FAIL step_width got=%b exp=0", oStep); else passed++;
    tick(3);
    exp_st = {6'd20, 5'd13, `TOP_DIR, 1'b1, 1'b0};
    total++; if (status !== exp_st) $display("FAIL second_step got=%h exp=%h", status, exp_st); else passed++;
  endtask

  task automatic test_reversal;
    iDirection = `DOWN_DIR;
    tick(4);
    exp_st = {6'd20, 5'd12, `TOP_DIR, 1'b1, 1'b0};
    total++; if (status !== exp_st) $display("FAIL reversal got=%h exp=%h", status, exp_st); else passed++;
  endtask

  task automatic test_late_change;
    iDirection = `LEFT_DIR;
    tick(3);
    iDirection = `RIGHT_DIR;
    tick(1);
    exp_st = {6'd21, 5'd12, `RIGHT_DIR, 1'b1, 1'b0};
    total++; if (status !== exp_st) $display("FAIL late_change got=%h exp=%h", status, exp_st); else passed++;
  endtask

  task automatic test_enable_drop;
    iDirection = `RIGHT_DIR;
    tick(3);
    iEnable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin tick(1); pulses += int'(oStep); end
    exp_st = {6'd21, 5'd12, `RIGHT_DIR, 1'b0, 1'b0};
    total++; if (pulses !== 0) $display("FAIL drop_pulses got=%0d exp=0", pulses); else passed++;
    total++; if (status !== exp_st) $display("FAIL drop_hold got=%h exp=%h", status, exp_st); else passed++;
    iEnable = 1'b1;
    tick(1);
    exp_st = {6'd22, 5'd12, `RIGHT_DIR, 1'b1, 1'b0};
    total++; if (status !== exp_st) $display("FAIL resume_step got=%h exp=%h", status, exp_st); else passed++;
  endtask

  task automatic test_reset_mid;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin tick(1); pulses += int'(oStep); end
    total++; if (pulses !== 5) $display("FAIL five_steps got=%0d exp=5", pulses); else passed++;
    exp_st = {6'd27, 5'd12, `RIGHT_DIR, 1'b1, 1'b0};
    total++; if (status !== exp_st) $display("FAIL five_steps_pos got=%h exp=%h", status, exp_st); else passed++;
    tick(2);
    iRst = 1'b1;
    tick(1);
    exp_st = {6'd20, 5'd15, `TOP_DIR, 1'b0, 1'b0};
    total++; if (status !== exp_st) $display("FAIL mid_reset got=%h exp=%h", status, exp_st); else passed++;
    total++; if (oState !== 2'd0) $display("FAIL mid_reset_state got=%0d exp=0", oState); else passed++;
    iRst = 1'b0;
    iDirection = `LEFT_DIR;
    tick(3);
    iRst = 1'b1;
    tick(1);
    total++; if (status !== exp_st) $display("FAIL reset_at_tc got=%h exp=%h", status, exp_st); else passed++;
    iRst = 1'b0;
  endtask

  task automatic test_wall;
    iDirection = `TOP_DIR;
    tick(40);
    iDirection = `LEFT_DIR;
    tick(80);
    exp_st = {6'd0, 5'd5, `LEFT_DIR, 1'b1, 1'b0};
    total++; if (status !== exp_st) $display("FAIL reach_edge got=%h exp=%h", status, exp_st); else passed++;
    tick(4);
`ifdef SNAKE_WRAP_AROUND_EN
    exp_st = {6'd39, 5'd5, `LEFT_DIR, 1'b1, 1'b0};
    total++; if (status !== exp_st) $display("FAIL wrap_step got=%h exp=%h", status, exp_st); else passed++;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin tick(1); pulses += int'(oStep); end
    total++; if (pulses !== 5) $display("FAIL wrap_pulses got=%0d exp=5", pulses); else passed++;
    exp_st = {6'd34, 5'd5, `LEFT_DIR, 1'b1, 1'b0};
    total++; if (status !== exp_st) $display("FAIL wrap_pos got=%h exp=%h", status, exp_st); else passed++;
`else
    exp_st = {6'd0, 5'd5, `LEFT_DIR, 1'b1, 1'b1};
    total++; if (status !== exp_st) $display("FAIL wall_hit got=%h exp=%h", status, exp_st); else passed++;
    total++; if (oState !== 2'd2) $display("FAIL dead_state got=%0d exp=2", oState); else passed++;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin tick(1); pulses += int'(oStep); end
    total++; if (pulses !== 0) $display("FAIL dead_pulses got=%0d exp=0", pulses); else passed++;
    exp_st = {6'd0, 5'd5, `LEFT_DIR, 1'b0, 1'b1};
    total++; if (status !== exp_st) $display("FAIL dead_hold got=%h exp=%h", status, exp_st); else passed++;
`endif
  endtask

  initial begin
    test_reset;
    test_first_steps;
    test_reversal;
    test_late_change;
    test_enable_drop;
    test_reset_mid;
    test_wall;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
